// File: rtl/dmem_bist_initiator.sv
// Data-memory BIST initiator: two-pass write/read-compare march over a word range,
// driving the Harvard data-memory strobes directly and reporting pass/fail.
module dmem_bist_initiator #(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int          NUM_WORDS    = 16,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] SEED         = 32'hA5A5_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] fail_address,
  output logic [31:0] fail_data,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_CMP      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [15:0] LAST_K    = 16'(NUM_WORDS - 1);
  localparam logic [2:0]  WAIT_INIT = 3'(READ_LATENCY - 1);

  state_t      r_state, w_state;
  logic [15:0] r_k, w_k;
  logic        r_pass_sel, w_pass_sel;
  logic [2:0]  r_wait, w_wait;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_pass, w_pass;
  logic [15:0] r_err_count, w_err_count;
  logic [31:0] r_fail_address, w_fail_address;
  logic [31:0] r_fail_data, w_fail_data;
  logic [31:0] r_data_address, w_data_address;
  logic        r_data_write, w_data_write;
  logic        r_data_read, w_data_read;
  logic [31:0] r_data_writedata, w_data_writedata;
  logic [31:0] w_expected;

  function automatic logic [31:0] f_word_addr(input logic [15:0] k);
    return ADDR_BASE + {14'd0, k, 2'b00};
  endfunction

  // Pattern is keyed on the byte address; pass 1 writes the complement.
  function automatic logic [31:0] f_pattern(input logic [31:0] addr, input logic inv);
    return inv ? ~(addr ^ SEED) : (addr ^ SEED);
  endfunction

  // Next-state and next-output computation; outputs are loaded for the state being entered.
  always_comb begin
    w_state          = r_state;
    w_k              = r_k;
    w_pass_sel       = r_pass_sel;
    w_wait           = r_wait;
    w_busy           = r_busy;
    w_done           = r_done;
    w_pass           = r_pass;
    w_err_count      = r_err_count;
    w_fail_address   = r_fail_address;
    w_fail_data      = r_fail_data;
    w_data_address   = r_data_address;
    w_data_write     = 1'b0;
    w_data_read      = 1'b0;
    w_data_writedata = r_data_writedata;
    w_expected       = f_pattern(r_data_address, r_pass_sel);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state          = S_WR;
          w_err_count      = 16'd0;
          w_fail_address   = 32'd0;
          w_fail_data      = 32'd0;
          w_done           = 1'b0;
          w_pass           = 1'b0;
          w_busy           = 1'b1;
          w_pass_sel       = 1'b0;
          w_k              = 16'd0;
          w_data_write     = 1'b1;
          w_data_address   = f_word_addr(16'd0);
          w_data_writedata = f_pattern(f_word_addr(16'd0), 1'b0);
        end else begin
          w_state = r_state;
        end
      end
      S_WR: begin
        if (r_k == LAST_K) begin
          w_k            = 16'd0;
          w_state        = S_RD_ISSUE;
          w_data_read    = 1'b1;
          w_data_address = f_word_addr(16'd0);
        end else begin
          w_k              = r_k + 16'd1;
          w_data_write     = 1'b1;
          w_data_address   = f_word_addr(r_k + 16'd1);
          w_data_writedata = f_pattern(f_word_addr(r_k + 16'd1), r_pass_sel);
        end
      end
      S_RD_ISSUE: begin
        w_wait = WAIT_INIT;
        if (READ_LATENCY == 1) begin
          w_state = S_CMP;
        end else begin
          w_state = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        w_wait = r_wait - 3'd1;
        if (r_wait <= 3'd1) begin
          w_state = S_CMP;
        end else begin
          w_state = S_RD_WAIT;
        end
      end
      S_CMP: begin
        if (data_readdata != w_expected) begin
          if (r_err_count != 16'hFFFF) begin
            w_err_count = r_err_count + 16'd1;
          end else begin
            w_err_count = r_err_count;
          end
          if (r_err_count == 16'd0) begin
            w_fail_address = r_data_address;
            w_fail_data    = data_readdata;
          end else begin
            w_fail_address = r_fail_address;
          end
        end else begin
          w_err_count = r_err_count;
        end

        if (r_k < LAST_K) begin
          w_k            = r_k + 16'd1;
          w_state        = S_RD_ISSUE;
          w_data_read    = 1'b1;
          w_data_address = f_word_addr(r_k + 16'd1);
        end else if (!r_pass_sel) begin
          w_pass_sel       = 1'b1;
          w_k              = 16'd0;
          w_state          = S_WR;
          w_data_write     = 1'b1;
          w_data_address   = f_word_addr(16'd0);
          w_data_writedata = f_pattern(f_word_addr(16'd0), 1'b1);
        end else begin
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = (w_err_count == 16'd0);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State and output registers; clk_enable low freezes everything including strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_k              <= 16'd0;
      r_pass_sel       <= 1'b0;
      r_wait           <= 3'd0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= 16'd0;
      r_fail_address   <= 32'd0;
      r_fail_data      <= 32'd0;
      r_data_address   <= 32'd0;
      r_data_write     <= 1'b0;
      r_data_read      <= 1'b0;
      r_data_writedata <= 32'd0;
    end else if (clk_enable) begin
      r_state          <= w_state;
      r_k              <= w_k;
      r_pass_sel       <= w_pass_sel;
      r_wait           <= w_wait;
      r_busy           <= w_busy;
      r_done           <= w_done;
      r_pass           <= w_pass;
      r_err_count      <= w_err_count;
      r_fail_address   <= w_fail_address;
      r_fail_data      <= w_fail_data;
      r_data_address   <= w_data_address;
      r_data_write     <= w_data_write;
      r_data_read      <= w_data_read;
      r_data_writedata <= w_data_writedata;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign fail_address   = r_fail_address;
  assign fail_data      = r_fail_data;
  assign data_address   = r_data_address;
  assign data_write     = r_data_write;
  assign data_read      = r_data_read;
  assign data_writedata = r_data_writedata;

endmodule
